regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined CPU: NRD

---
 rtl/regfile_mp_sb.sv | 144 ++++++++++++++
 tb/tb_regfile_mp_sb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register scoreboard.
// NRD combinational read ports, two writeback ports (WB0 main pipe, WB1
// long-latency unit), optional same-cycle write-to-read bypass, and busy
// bits that are set at issue and cleared at writeback.
//
// Port protocol: there is no valid/ready handshake. wr_en[i] qualifies
// wr_addr_i/wr_data_i for the current cycle, and iss_en qualifies iss_addr.
// Each is sampled on the rising edge and cannot be back-pressured. Decode is
// expected to stall on rd_busy itself.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [1:0]          wr_en,
    input  logic [AW-1:0]       wr_addr0,
    input  logic [XLEN-1:0]     wr_data0,
    input  logic [AW-1:0]       wr_addr1,
    input  logic [XLEN-1:0]     wr_data1,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic                err_dup,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            we0;
    logic            we1;
    logic            iss_ok;
    logic            dup_hit;

    // With a hardwired zero register, writes and issues to address 0 vanish
    // here, so neither the storage, the scoreboard nor the bypass sees them.
    assign we0    = wr_en[0] && !((ZERO_REG != 0) && (wr_addr0 == '0));
    assign we1    = wr_en[1] && !((ZERO_REG != 0) && (wr_addr1 == '0));
    assign iss_ok = iss_en   && !((ZERO_REG != 0) && (iss_addr == '0));

    // A duplicate issue is only an error if no writeback retires the old
    // producer in the same cycle.
    assign dup_hit = iss_ok && !flush && busy[iss_addr]
                   && !(we0 && (wr_addr0 == iss_addr))
                   && !(we1 && (wr_addr1 == iss_addr));

    // Register storage: WB1 is applied after WB0 so it wins on an address tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0) begin
                regs[wr_addr0] <= wr_data0;
            end
            if (we1) begin
                regs[wr_addr1] <= wr_data1;
            end
        end
    end

    // Scoreboard next state: flush beats issue, and issue beats the
    // write-clear because the newly issued producer supersedes the old one.
    always_comb begin
        busy_nxt = busy;
        if (we0) begin
            busy_nxt[wr_addr0] = 1'b0;
        end
        if (we1) begin
            busy_nxt[wr_addr1] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // Popcount of the next busy vector so that busy_cnt moves with busy.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    // Scoreboard, busy count and sticky duplicate-issue flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            err_dup  <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (dup_hit) begin
                err_dup <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = rd_addr[k*AW +: AW];

        // Read mux: stored value, overridden by bypass, overridden by zero reg.
        always_comb begin
            d = regs[a];
            b = busy[a];
            if (BYPASS != 0) begin
                if (we0 && (wr_addr0 == a)) begin
                    d = wr_data0;
                    b = 1'b0;
                end
                if (we1 && (wr_addr1 == a)) begin
                    d = wr_data1;
                    b = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (a == '0)) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = d;
        assign rd_busy[k]              = b;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb (XLEN=32, NREG=32, NRD=2, ZERO_REG=1, BYPASS=1).
// The driver applies inputs just after a rising edge and pushes the expected
// outputs into exp_q. The monitor drains exp_q on every falling edge and
// compares each entry against the DUT output it names.
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    // Entry layout: {test tag[7:0], selector[3:0], value[XLEN-1:0]}
    localparam int EW   = 8 + 4 + XLEN;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [1:0]          wr_en;
    logic [AW-1:0]       wr_addr0;
    logic [XLEN-1:0]     wr_data0;
    logic [AW-1:0]       wr_addr1;
    logic [XLEN-1:0]     wr_data1;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic                err_dup;
    logic [AW:0]         busy_cnt;

    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [7:0]    tag    = 8'd0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    regfile_mp_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en),
        .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .err_dup(err_dup), .busy_cnt(busy_cnt)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        wr_en    = 2'b00;
        wr_addr0 = '0;
        wr_data0 = '0;
        wr_addr1 = '0;
        wr_data1 = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    task automatic push(input int sel, input logic [XLEN-1:0] v);
        exp_q.push_back({tag, 4'(sel), v});
    endtask

    task automatic exp_rd(input int k, input logic [XLEN-1:0] d, input logic b);
        push(k, d);
        push(2 + k, XLEN'(b));
    endtask

    task automatic exp_cnt(input int v);
        push(4, XLEN'(v));
    endtask

    task automatic exp_err(input logic v);
        push(5, XLEN'(v));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0]   e;
        logic [XLEN-1:0] act;
        logic [XLEN-1:0] req;
        string           nm;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            req = e[XLEN-1:0];
            case (int'(e[XLEN +: 4]))
                0: begin act = rd_data[0 +: XLEN];     nm = "rd_data0"; end
                1: begin act = rd_data[XLEN +: XLEN];  nm = "rd_data1"; end
                2: begin act = XLEN'(rd_busy[0]);      nm = "rd_busy0"; end
                3: begin act = XLEN'(rd_busy[1]);      nm = "rd_busy1"; end
                4: begin act = XLEN'(busy_cnt);        nm = "busy_cnt"; end
                default: begin act = XLEN'(err_dup);   nm = "err_dup";  end
            endcase
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL t%0d %s actual=0x%0h required=0x%0h",
                         e[EW-1 -: 8], nm, act, req);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        rd_addr = '0;

        // Held in reset: registered outputs clear.
        tag = 8'd0;
        tick();
        exp_cnt(0);
        exp_err(1'b0);
        tick();
        rst = 1'b1;

        // 1: every register reads 0 and not busy on both ports.
        tag = 8'd1;
        for (int a = 0; a < NREG; a++) begin
            tick();
            set_rd(0, AW'(a));
            set_rd(1, AW'(NREG - 1 - a));
            exp_rd(0, '0, 1'b0);
            exp_rd(1, '0, 1'b0);
            exp_cnt(0);
        end
        exp_err(1'b0);

        // 2: bypass of a WB0 write, then the stored value.
        tag = 8'd2;
        tick();
        wr_en = 2'b01; wr_addr0 = 5; wr_data0 = 32'hDEAD_BEEF;
        set_rd(0, 5); set_rd(1, 5);
        exp_rd(0, 32'hDEAD_BEEF, 1'b0);
        exp_rd(1, 32'hDEAD_BEEF, 1'b0);
        tick();
        set_rd(0, 5); set_rd(1, 6);
        exp_rd(0, 32'hDEAD_BEEF, 1'b0);
        exp_rd(1, '0, 1'b0);

        // 3: WB1 wins an address tie; disjoint dual write; zero register.
        tag = 8'd3;
        tick();
        wr_en = 2'b11; wr_addr0 = 7; wr_data0 = 32'h1111; wr_addr1 = 7; wr_data1 = 32'h2222;
        set_rd(0, 7);
        exp_rd(0, 32'h2222, 1'b0);
        tick();
        set_rd(0, 7); set_rd(1, 5);
        exp_rd(0, 32'h2222, 1'b0);
        exp_rd(1, 32'hDEAD_BEEF, 1'b0);
        tick();
        wr_en = 2'b11; wr_addr0 = 20; wr_data0 = 32'hA0A0_0001; wr_addr1 = 21; wr_data1 = 32'hB0B0_0002;
        tick();
        set_rd(0, 20); set_rd(1, 21);
        exp_rd(0, 32'hA0A0_0001, 1'b0);
        exp_rd(1, 32'hB0B0_0002, 1'b0);
        tick();
        wr_en = 2'b11; wr_addr0 = 0; wr_data0 = 32'hFFFF_FFFF; wr_addr1 = 0; wr_data1 = 32'h1234_5678;
        set_rd(0, 0);
        exp_rd(0, '0, 1'b0);
        tick();
        set_rd(0, 0);
        exp_rd(0, '0, 1'b0);

        // 4: issue, duplicate issue, write+issue, write alone.
        tag = 8'd4;
        tick();
        issue(9); set_rd(0, 9);
        exp_rd(0, '0, 1'b0);
        exp_cnt(0);
        tick();
        set_rd(0, 9);
        exp_rd(0, '0, 1'b1);
        exp_cnt(1);
        exp_err(1'b0);
        tick();
        issue(9);
        exp_err(1'b0);
        tick();
        exp_err(1'b1);
        exp_rd(0, '0, 1'b1);
        exp_cnt(1);
        tick();
        issue(9); wr_en = 2'b01; wr_addr0 = 9; wr_data0 = 32'h99;
        exp_rd(0, 32'h99, 1'b0);
        tick();
        exp_rd(0, 32'h99, 1'b1);
        exp_cnt(1);
        tick();
        wr_en = 2'b10; wr_addr1 = 9; wr_data1 = 32'hAA;
        exp_rd(0, 32'hAA, 1'b0);
        exp_cnt(1);
        tick();
        exp_rd(0, 32'hAA, 1'b0);
        exp_cnt(0);
        exp_err(1'b1);

        // 5: three issues, then flush together with an issue of 8.
        tag = 8'd5;
        tick(); issue(3);
        tick(); issue(4);
        tick(); issue(6);
        exp_cnt(2);
        tick();
        flush = 1'b1; issue(8);
        set_rd(0, 3); set_rd(1, 8);
        exp_rd(0, '0, 1'b1);
        exp_rd(1, '0, 1'b0);
        exp_cnt(3);
        tick();
        set_rd(0, 3); set_rd(1, 8);
        exp_rd(0, '0, 1'b0);
        exp_rd(1, '0, 1'b0);
        exp_cnt(0);
        tick();
        set_rd(0, 4); set_rd(1, 6);
        exp_rd(0, '0, 1'b0);
        exp_rd(1, '0, 1'b0);

        // 6: asynchronous reset mid-stream with busy and err set.
        tag = 8'd6;
        tick(); issue(10);
        tick(); issue(11);
        tick();
        exp_cnt(2);
        exp_err(1'b1);
        tick();
        rst = 1'b0;
        issue(13); wr_en = 2'b01; wr_addr0 = 14; wr_data0 = 32'h77;
        set_rd(0, 10); set_rd(1, 7);
        exp_rd(0, '0, 1'b0);
        exp_rd(1, '0, 1'b0);
        exp_cnt(0);
        exp_err(1'b0);
        @(posedge clk);
        #1;
        exp_rd(0, '0, 1'b0);
        exp_rd(1, '0, 1'b0);
        exp_cnt(0);
        tick();
        rst = 1'b1;
        set_rd(0, 13); set_rd(1, 14);
        exp_rd(0, '0, 1'b0);
        exp_rd(1, '0, 1'b0);
        exp_cnt(0);
        exp_err(1'b0);

        // 7: err_dup boundaries with a clean flag.
        tag = 8'd7;
        tick(); issue(12);
        tick();
        issue(12); wr_en = 2'b01; wr_addr0 = 12; wr_data0 = 32'h55;
        set_rd(0, 12);
        exp_rd(0, 32'h55, 1'b0);
        tick();
        set_rd(0, 12);
        exp_rd(0, 32'h55, 1'b1);
        exp_cnt(1);
        exp_err(1'b0);
        tick();
        flush = 1'b1; issue(12);
        tick();
        exp_err(1'b0);
        exp_cnt(0);
        exp_rd(0, 32'h55, 1'b0);
        tick(); issue(0);
        tick();
        set_rd(0, 0);
        exp_rd(0, '0, 1'b0);
        exp_cnt(0);
        tick(); issue(15);
        tick();
        issue(15); wr_en = 2'b01; wr_addr0 = 16; wr_data0 = 32'h1;
        exp_err(1'b0);
        tick();
        exp_err(1'b1);
        exp_cnt(1);

        // Drain and final report.
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_q_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
